// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS IF stage.
//   NOP_INSTR   - encoding loaded into IF/ID when a slot is empty
//   PC_INCR     - sequential PC step in bytes
//   INSTR_BYTES - bytes per instruction word
//   npc_sel_e   - next-PC source selector
package mips_pkg;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam logic [31:0] PC_INCR     = 32'd4;
   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      NPC_SEQ,
      NPC_HOLD,
      NPC_BRANCH,
      NPC_JUMP
   } npc_sel_e;

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register.
//   clk, rst_n    - clock, asynchronous active-low reset
//   i_load        - capture i_instr / i_pc_plus4 and mark the slot valid
//   i_flush       - empty the slot (NOP, invalid); wins over i_load
//   i_instr       - fetched instruction word
//   i_pc_plus4    - PC+4 of the fetched instruction
//   o_instr       - latched instruction (NOP when invalid)
//   o_pc_plus4    - latched PC+4
//   o_valid       - slot holds a real instruction
// With neither control asserted the register holds its contents.
module ifid_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc_plus4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc_plus4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc_plus4;
   logic        r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr    <= NOP_INSTR;
         r_pc_plus4 <= 32'h0;
         r_valid    <= 1'b0;
      end else if (i_flush) begin
         // PC+4 is left untouched: it is meaningless while the slot is invalid.
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr    <= i_instr;
         r_pc_plus4 <= i_pc_plus4;
         r_valid    <= 1'b1;
      end
   end

   assign o_instr    = r_instr;
   assign o_pc_plus4 = r_pc_plus4;
   assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the MIPS pipeline.
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   Address       - current PC driven to instruction memory
//   Instruction   - word returned combinationally for Address
//   Stall         - hold PC and IF/ID
//   BranchTaken   - branch in ID taken; target = IfIdPcPlus4 + BranchOffset*4
//   BranchOffset  - sign-extended word offset of that branch
//   JumpTaken     - j/jal in ID; target = {IfIdPcPlus4[31:28], JumpIndex, 2'b00}
//   JumpIndex     - instr_index of that jump
//   IfIdInstr     - IF/ID instruction (NOP when invalid)
//   IfIdPcPlus4   - IF/ID PC+4
//   IfIdValid     - IF/ID holds a real instruction
//   FetchFault    - sticky: a fetch was attempted outside instruction memory
//   FetchCount    - count of valid instructions loaded into IF/ID
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] Address,
   input  logic [31:0] Instruction,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchOffset,
   input  logic        JumpTaken,
   input  logic [25:0] JumpIndex,
   output logic [31:0] IfIdInstr,
   output logic [31:0] IfIdPcPlus4,
   output logic        IfIdValid,
   output logic        FetchFault,
   output logic [31:0] FetchCount
);

   logic [31:0] r_pc;
   logic        r_fault;
   logic [31:0] r_count;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_next;
   logic [31:0] w_branch_tgt;
   logic [31:0] w_jump_tgt;
   logic        w_redirect;
   logic        w_in_range;
   logic        w_load;
   logic        w_flush;
   logic        w_fault_set;
   npc_sel_e    w_sel;
   logic [31:0] w_id_instr;
   logic [31:0] w_id_pc_plus4;
   logic        w_id_valid;
   logic        w_unused_ofs_hi;

   assign w_pc_plus4   = r_pc + PC_INCR;
   assign w_branch_tgt = w_id_pc_plus4 + {BranchOffset[29:0], 2'b00};
   assign w_jump_tgt   = {w_id_pc_plus4[31:28], JumpIndex, 2'b00};
   // Offset bits above 29 shift out of the 32-bit target.
   assign w_unused_ofs_hi = ^BranchOffset[31:30];

   // Redirects come from the instruction sitting in ID; an empty slot cannot redirect.
   assign w_redirect = w_id_valid & (JumpTaken | BranchTaken);

   // Last byte of the word must lie inside memory; 33 bits so PC near 2^32 cannot wrap.
   assign w_in_range = ({1'b0, r_pc} + 33'(INSTR_BYTES - 1)) < 33'(MEM_BYTES);

   always_comb begin
      w_sel       = NPC_SEQ;
      w_load      = 1'b0;
      w_flush     = 1'b0;
      w_fault_set = 1'b0;
      if (w_redirect) begin
         // Jump beats branch; Stall is ignored because the fetched slot is wrong-path.
         w_sel   = JumpTaken ? NPC_JUMP : NPC_BRANCH;
         w_flush = 1'b1;
      end else if (Stall) begin
         w_sel = NPC_HOLD;
      end else if (!w_in_range) begin
         w_sel       = NPC_HOLD;
         w_flush     = 1'b1;
         w_fault_set = 1'b1;
      end else begin
         w_sel  = NPC_SEQ;
         w_load = 1'b1;
      end
   end

   always_comb begin
      w_pc_next = r_pc;
      case (w_sel)
         NPC_SEQ:    w_pc_next = w_pc_plus4;
         NPC_HOLD:   w_pc_next = r_pc;
         NPC_BRANCH: w_pc_next = w_branch_tgt;
         NPC_JUMP:   w_pc_next = w_jump_tgt;
         default:    w_pc_next = r_pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
         r_count <= 32'h0;
      end else begin
         r_pc <= w_pc_next;
         if (w_fault_set) begin
            r_fault <= 1'b1;
         end
         if (w_load) begin
            r_count <= r_count + 32'd1;
         end
      end
   end

   ifid_reg u_ifid (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_flush    (w_flush),
      .i_instr    (Instruction),
      .i_pc_plus4 (w_pc_plus4),
      .o_instr    (w_id_instr),
      .o_pc_plus4 (w_id_pc_plus4),
      .o_valid    (w_id_valid)
   );

   assign Address     = r_pc;
   assign IfIdInstr   = w_id_instr;
   assign IfIdPcPlus4 = w_id_pc_plus4;
   assign IfIdValid   = w_id_valid;
   assign FetchFault  = r_fault;
   assign FetchCount  = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage. Models a 128-byte big-endian
// instruction memory and keeps an abstract model of the PC / IF/ID state.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] Address;
   logic [31:0] Instruction;
   logic        Stall;
   logic        BranchTaken;
   logic [31:0] BranchOffset;
   logic        JumpTaken;
   logic [25:0] JumpIndex;
   logic [31:0] IfIdInstr;
   logic [31:0] IfIdPcPlus4;
   logic        IfIdValid;
   logic        FetchFault;
   logic [31:0] FetchCount;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [0:127];

   // model state
   logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
   logic        m_valid, m_fault;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0), .MEM_BYTES(128)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Address      (Address),
      .Instruction  (Instruction),
      .Stall        (Stall),
      .BranchTaken  (BranchTaken),
      .BranchOffset (BranchOffset),
      .JumpTaken    (JumpTaken),
      .JumpIndex    (JumpIndex),
      .IfIdInstr    (IfIdInstr),
      .IfIdPcPlus4  (IfIdPcPlus4),
      .IfIdValid    (IfIdValid),
      .FetchFault   (FetchFault),
      .FetchCount   (FetchCount)
   );

   function automatic logic [31:0] memword(input logic [31:0] a);
      int i;
      i = int'(a[6:0]);
      return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
   endfunction

   // combinational instruction memory; out-of-range reads return a marker word
   always_comb begin
      Instruction = 32'hFFFF_FFFF;
      if (Address <= 32'd124) Instruction = memword(Address);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc"},    Address,              m_pc);
      chk({tag, ".instr"}, IfIdInstr,            m_instr);
      chk({tag, ".pc4"},   IfIdPcPlus4,          m_pc4);
      chk({tag, ".valid"}, {31'h0, IfIdValid},   {31'h0, m_valid});
      chk({tag, ".fault"}, {31'h0, FetchFault},  {31'h0, m_fault});
      chk({tag, ".count"}, FetchCount,           m_cnt);
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
      m_valid = 1'b0; m_fault = 1'b0;
   endtask

   // One clock edge: predict from the current inputs, then compare after the edge.
   task automatic step(input string tag);
      logic [31:0] n_pc, n_instr, n_pc4, n_cnt;
      logic        n_valid, n_fault;
      n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_cnt = m_cnt;
      n_valid = m_valid; n_fault = m_fault;
      if (m_valid && (JumpTaken || BranchTaken)) begin
         if (JumpTaken) n_pc = {m_pc4[31:28], JumpIndex, 2'b00};
         else           n_pc = m_pc4 + (BranchOffset << 2);
         n_instr = 32'h0;
         n_valid = 1'b0;
      end else if (Stall) begin
         // everything holds
      end else if (longint'(m_pc) + 3 >= 128) begin
         n_instr = 32'h0;
         n_valid = 1'b0;
         n_fault = 1'b1;
      end else begin
         n_instr = memword(m_pc);
         n_pc4   = m_pc + 32'd4;
         n_pc    = m_pc + 32'd4;
         n_valid = 1'b1;
         n_cnt   = m_cnt + 32'd1;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_cnt = n_cnt;
      m_valid = n_valid; m_fault = n_fault;
      chk_all(tag);
      $display("step %-6s pc=%h instr=%h pc4=%h v=%0d f=%0d cnt=%0d", tag,
               Address, IfIdInstr, IfIdPcPlus4, IfIdValid, FetchFault, FetchCount);
   endtask

   // Assert reset between edges and check the outputs clear before any edge.
   task automatic async_reset(input string tag);
      #3 rst_n = 1'b0;
      #1 model_reset();
      chk_all(tag);
      $display("reset %-6s pc=%h v=%0d f=%0d cnt=%0d", tag, Address, IfIdValid, FetchFault, FetchCount);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clear_ctl();
      Stall = 1'b0; BranchTaken = 1'b0; JumpTaken = 1'b0;
      BranchOffset = 32'h0; JumpIndex = 26'h0;
   endtask

   initial begin
      logic [31:0] rw;
      mem[0]  = 8'h20; mem[1]  = 8'h02; mem[2]  = 8'h00; mem[3]  = 8'h01;
      mem[4]  = 8'h20; mem[5]  = 8'h03; mem[6]  = 8'h00; mem[7]  = 8'h02;
      mem[8]  = 8'h00; mem[9]  = 8'h00; mem[10] = 8'h00; mem[11] = 8'h00;
      mem[12] = 8'h01; mem[13] = 8'h03; mem[14] = 8'h40; mem[15] = 8'h20;
      for (int i = 16; i < 128; i += 4) begin
         rw = $urandom;
         mem[i] = rw[31:24]; mem[i+1] = rw[23:16]; mem[i+2] = rw[15:8]; mem[i+3] = rw[7:0];
      end

      rst_n = 1'b0;
      clear_ctl();
      model_reset();
      #12;
      chk_all("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: four free fetches
      for (int k = 0; k < 4; k++) step("seq");
      chk("t1.instr", IfIdInstr, 32'h0103_4020);
      chk("t1.pc4",   IfIdPcPlus4, 32'd16);
      chk("t1.count", FetchCount, 32'd4);

      // 2: stall two cycles after the second fetch
      async_reset("t2r");
      step("t2a"); step("t2b");
      Stall = 1'b1;
      step("t2s"); step("t2s");
      chk("t2.pc",    Address, 32'd8);
      chk("t2.instr", IfIdInstr, 32'h2003_0002);
      chk("t2.count", FetchCount, 32'd2);
      Stall = 1'b0;

      // 3: taken branch, offset -2 from PC+4 = 8 -> 0
      BranchTaken = 1'b1; BranchOffset = 32'hFFFF_FFFE;
      step("t3br");
      chk("t3.pc",    Address, 32'd0);
      chk("t3.valid", {31'h0, IfIdValid}, 32'd0);
      clear_ctl();
      step("t3f");
      chk("t3.refetch", IfIdInstr, 32'h2002_0001);

      // 4: jump, branch and stall together; jump wins
      JumpTaken = 1'b1; BranchTaken = 1'b1; Stall = 1'b1;
      JumpIndex = 26'd3; BranchOffset = 32'd5;
      step("t4");
      chk("t4.pc",    Address, 32'd12);
      chk("t4.instr", IfIdInstr, 32'h0);
      clear_ctl();

      // 5: run off the end of memory
      for (int k = 0; k < 64 && m_pc != 32'd128; k++) step("t5run");
      chk("t5.reach128", Address, 32'd128);
      // slot still valid (word at 124): a jump here wins over the fault
      JumpTaken = 1'b1; JumpIndex = 26'd0;
      step("t5j");
      chk("t5.jpc",   Address, 32'd0);
      chk("t5.nofault", {31'h0, FetchFault}, 32'd0);
      clear_ctl();
      for (int k = 0; k < 64 && !m_fault; k++) step("t5run");
      chk("t5.fault", {31'h0, FetchFault}, 32'd1);
      chk("t5.valid", {31'h0, IfIdValid}, 32'd0);
      chk("t5.pc",    Address, 32'd128);
      // empty slot: the redirect is not qualified and the PC stays put
      JumpTaken = 1'b1; JumpIndex = 26'd0;
      step("t5jx");
      chk("t5.hold", Address, 32'd128);
      clear_ctl();

      // 6: reset asynchronously in the middle of a stall
      Stall = 1'b1;
      step("t6s");
      async_reset("t6r");
      Stall = 1'b0;
      step("t6f");
      chk("t6.instr", IfIdInstr, 32'h2002_0001);

      // random phase
      for (int n = 0; n < 400; n++) begin
         Stall       = ($urandom_range(0, 99) < 15);
         BranchTaken = ($urandom_range(0, 9) == 0);
         JumpTaken   = ($urandom_range(0, 11) == 0);
         JumpIndex   = ($urandom_range(0, 3) == 0) ? 26'($urandom_range(29, 40))
                                                   : 26'($urandom_range(0, 31));
         BranchOffset = 32'($urandom_range(0, 16)) - 32'd8;
         step("rnd");
         if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 79) == 0) begin
            async_reset("rndr");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
